// File: rtl/quat_result_serializer_pkg.sv
// Shared types and constants for the quaternion result serializer.
// Holds FSM encoding, component indices, saturation limits and the FIFO entry.
package quat_result_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [1:0] IDX_W = 2'd0;
  localparam logic [1:0] IDX_X = 2'd1;
  localparam logic [1:0] IDX_Y = 2'd2;
  localparam logic [1:0] IDX_Z = 2'd3;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef struct packed {
    logic [3:0][15:0] data;
    logic [3:0]       sat;
  } q_entry_t;

endpackage

// File: rtl/quat_result_serializer_rescale.sv
// Round-half-up, arithmetic shift and 16-bit clamp of one
// 32-bit product sum.
module q_rescale_sat
  import quat_result_serializer_pkg::*;
#(
  parameter int FRAC_BITS = 15
) (
  input  logic [31:0] i_val,
  output logic [15:0] o_val,
  output logic        o_sat
);

  localparam logic signed [32:0] HALF =
    33'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [32:0] MAX33 =
    {{17{SAT_MAX[15]}}, SAT_MAX};
  localparam logic signed [32:0] MIN33 =
    {{17{SAT_MIN[15]}}, SAT_MIN};

  logic signed [32:0] w_sum;
  logic signed [32:0] w_shr;

  // 33 bits so the rounding add cannot wrap at the top of range
  assign w_sum = $signed({i_val[31], i_val}) + HALF;
  assign w_shr = w_sum >>> FRAC_BITS;

  always_comb begin
    o_val = w_shr[15:0];
    o_sat = 1'b0;
    if (w_shr > MAX33) begin
      o_val = SAT_MAX;
      o_sat = 1'b1;
    end else if (w_shr < MIN33) begin
      o_val = SAT_MIN;
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/quat_result_serializer.sv
// Buffers whole quaternion results and streams them out
// one rescaled 16-bit component per beat.
module quat_result_serializer
  import quat_result_serializer_pkg::*;
#(
  parameter int FRAC_BITS = 15,
  parameter int DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  input  logic [31:0] r4,
  output logic [15:0] out_data,
  output logic [1:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_sat,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  q_entry_t         r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_beat;
  logic             r_ovf;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [3:0][31:0] w_r;
  q_entry_t         w_entry;
  q_entry_t         w_head;
  logic             w_full;
  logic             w_hs;
  logic             w_pop;
  logic             w_free;
  logic             w_push;
  logic             w_drop;

  assign w_r = {r4, r3, r2, r1};

  for (genvar g = 0; g < 4; g++) begin : g_rs
    q_rescale_sat #(
      .FRAC_BITS(FRAC_BITS)
    ) u_rs (
      .i_val(w_r[g]),
      .o_val(w_entry.data[g]),
      .o_sat(w_entry.sat[g])
    );
  end

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_hs   = (r_state == ST_SEND) && out_ready;
  assign w_pop  = w_hs && (r_beat == IDX_Z);
  // popping the last beat frees the head slot this very cycle
  assign w_free = !w_full || w_pop;
  assign w_push = in_valid && w_free;
  assign w_drop = in_valid && !w_free;
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_ovf   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_beat <= '0;
      end else if (w_hs) begin
        r_beat <= r_beat + 2'd1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_cnt != '0) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_pop && (w_cnt_nxt == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = IDX_W;
    out_last  = 1'b0;
    out_sat   = 1'b0;
    if (r_state == ST_SEND) begin
      out_valid = 1'b1;
      out_data  = w_head.data[r_beat];
      out_idx   = r_beat;
      out_last  = (r_beat == IDX_Z);
      out_sat   = w_head.sat[r_beat];
    end
  end

  assign ovf  = r_ovf;
  assign full = w_full;

endmodule

// File: tb/tb_quat_result_serializer.sv
// Directed bench for quat_result_serializer: rescale table
// plus backpressure, overflow, simultaneity and reset cases.
module tb_quat_result_serializer;

  typedef struct packed {
    logic [3:0][31:0] r;
    logic [3:0][15:0] d;
    logic [3:0]       s;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] r1 = '0;
  logic [31:0] r2 = '0;
  logic [31:0] r3 = '0;
  logic [31:0] r4 = '0;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        out_sat;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic        full;

  vec_t vt [4];
  int   n_pass = 0;
  int   n_total = 0;

  quat_result_serializer #(
    .FRAC_BITS(15),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .r1(r1),
    .r2(r2),
    .r3(r3),
    .r4(r4),
    .out_data(out_data),
    .out_idx(out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .out_sat(out_sat),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] obs();
    return {11'd0, out_valid, out_idx, out_last,
            out_sat, out_data};
  endfunction

  function automatic logic [31:0] beat(input int v,
                                       input int k);
    logic [1:0] idx;
    idx = 2'(k);
    return {11'd0, 1'b1, idx, (k == 3),
            vt[v].s[k], vt[v].d[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    r1 = vt[v].r[0];
    r2 = vt[v].r[1];
    r3 = vt[v].r[2];
    r4 = vt[v].r[3];
  endtask

  task automatic push(input int v);
    load(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_beats(input int v,
                              input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_v%0d_b%0d", tag, v, k),
            obs(), beat(v, k));
      step();
    end
  endtask

  initial begin
    vt[0].r = {32'hBFFF0000, 32'h40000000,
               32'h3FFF8000, 32'h00008000};
    vt[0].d = {16'h8000, 16'h7FFF, 16'h7FFF, 16'h0001};
    vt[0].s = 4'b1100;
    vt[1].r = {32'h00000000, 32'hC0000000,
               32'hFFFFBFFF, 32'hFFFFC000};
    vt[1].d = {16'h0000, 16'h8000, 16'hFFFF, 16'h0000};
    vt[1].s = 4'b0000;
    vt[2].r = {32'h00003FFF, 32'h00004000,
               32'h80000000, 32'h7FFFFFFF};
    vt[2].d = {16'h0000, 16'h0001, 16'h8000, 16'h7FFF};
    vt[2].s = 4'b0011;
    vt[3].r = {32'hBFFFBFFF, 32'h3FFFC000,
               32'h3FFF3FFF, 32'hFFFF8000};
    vt[3].d = {16'h8000, 16'h7FFF, 16'h7FFE, 16'hFFFF};
    vt[3].s = 4'b1100;

    step();
    check("rst_outs", obs(), 32'd0);
    check("rst_flags", {30'd0, ovf, full}, 32'd0);
    rst = 1'b1;
    step();
    check("post_rst_idle", obs(), 32'd0);

    for (int v = 0; v < 4; v++) begin
      push(v);
      check($sformatf("lat_v%0d", v),
            {31'd0, out_valid}, 32'd0);
      step();
      expect_beats(v, "tbl");
      check($sformatf("idle_v%0d", v),
            {31'd0, out_valid}, 32'd0);
    end

    // backpressure mid-burst
    push(0);
    step();
    check("bp_b0", obs(), beat(0, 0));
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), obs(), beat(0, 1));
      step();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      check($sformatf("bp_b%0d", k), obs(), beat(0, k));
      step();
    end
    check("bp_idle", {31'd0, out_valid}, 32'd0);

    // overflow: third result dropped
    out_ready = 1'b0;
    push(0);
    check("ovf_full1", {31'd0, full}, 32'd0);
    push(1);
    check("ovf_full2", {30'd0, ovf, full}, 32'd1);
    push(2);
    check("ovf_set", {30'd0, ovf, full}, 32'd3);
    out_ready = 1'b1;
    expect_beats(0, "ovf");
    expect_beats(1, "ovf");
    check("ovf_drain", {30'd0, out_valid, full}, 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", {31'd0, ovf}, 32'd0);

    // push on the idx-3 handshake of a full FIFO
    out_ready = 1'b0;
    push(0);
    push(1);
    check("sim_full", {31'd0, full}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sim_b%0d", k), obs(), beat(0, k));
      step();
    end
    check("sim_b3", obs(), beat(0, 3));
    load(3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("sim_acc", {30'd0, ovf, full}, 32'd1);
    out_ready = 1'b0;
    load(2);
    in_valid = 1'b1;
    ovf_clr = 1'b1;
    step();
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    check("sim_setwins", {30'd0, ovf, full}, 32'd3);
    out_ready = 1'b1;
    expect_beats(1, "sim");
    expect_beats(3, "sim");
    check("sim_idle", {31'd0, out_valid}, 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // reset during beat 2
    push(0);
    step();
    check("rb_b0", obs(), beat(0, 0));
    step();
    check("rb_b1", obs(), beat(0, 1));
    step();
    check("rb_b2", obs(), beat(0, 2));
    rst = 1'b0;
    #1;
    check("rb_async", obs(), 32'd0);
    check("rb_flags", {30'd0, ovf, full}, 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rb_quiet%0d", i), obs(), 32'd0);
    end
    push(1);
    step();
    expect_beats(1, "rb");
    check("rb_idle", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/quat_result_serializer.md
QUAT_RESULT_SERIALIZER -- requirements
Module: quat_result_serializer

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 15, meaning the number of fractional bits removed when rescaling a 32-bit product sum to 16 bits (legal range 1..16).
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of whole quaternion results buffered (legal values: powers of two, 2 or more).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: single-cycle strobe qualifying r1..r4 (the multiplier's valid output).
REQ-006 SHALL have ports r1, r2, r3, r4, input, 32 bits each: signed quaternion components w, x, y, z.
REQ-007 SHALL have port out_data, output, 16 bits: signed rescaled component.
REQ-008 SHALL have port out_idx, output, 2 bits: component index (0 = r1 ... 3 = r4).
REQ-009 SHALL have port out_valid, output, 1 bit: out_data, out_idx, out_last and out_sat are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the current beat.
REQ-011 SHALL have port out_last, output, 1 bit: asserted on the beat where out_idx = 3.
REQ-012 SHALL have port out_sat, output, 1 bit: the current beat was clamped.
REQ-013 SHALL have port ovf, output, 1 bit: sticky flag set when a result is dropped.
REQ-014 SHALL have port ovf_clr, input, 1 bit: synchronous clear of ovf.
REQ-015 SHALL have port full, output, 1 bit: all DEPTH slots are occupied.

Function
REQ-016 Rescale each component at capture: add 2^(FRAC_BITS-1) (round half up, 33-bit intermediate, no wrap), arithmetic shift right by FRAC_BITS, clamp to [-32768, 32767]; store the 16-bit value plus a per-component sat bit.
REQ-017 On in_valid with a free slot, all four rescaled components SHALL be written to one FIFO slot in that cycle.
REQ-018 A slot counts as free when full=0, or when the final beat (idx 3) of the head entry is handshaken in the same cycle; simultaneous write and read SHALL leave the occupancy unchanged.
REQ-019 On in_valid with no free slot, the result SHALL be dropped, ovf SHALL be set the next cycle, and the FIFO contents SHALL be unchanged.
REQ-020 If ovf_clr and a drop occur in the same cycle, ovf SHALL end up set (set wins).
REQ-021 Latency: a result captured at edge N SHALL give out_valid=1 from edge N+1 when the FIFO was empty.
REQ-022 Output FSM states: IDLE (FIFO empty, out_valid=0) and SEND (out_valid=1, beat counter 0..3).
REQ-023 IDLE->SEND when the FIFO becomes non-empty; the beat counter advances only on out_valid&&out_ready.
REQ-024 On the handshake with idx 3, the FSM SHALL pop the head entry, reset the counter to 0, and stay in SEND if entries remain, otherwise go to IDLE.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_idx, out_last and out_sat SHALL hold stable.
REQ-026 Beats SHALL be emitted in order r1, r2, r3, r4 with no gaps while out_ready=1; the FIFO SHALL wrap read and write pointers modulo DEPTH.

Reset
REQ-027 While rst=0: FIFO empty, pointers and beat counter 0, FSM in IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, out_sat=0, ovf=0, full=0.
REQ-028 Reset asserted mid-burst SHALL discard all buffered and partially sent results immediately; no beat is emitted after release until a new in_valid.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the component-index constants (IDX_W=0 .. IDX_Z=3) and the 16-bit saturation limits.
REQ-030 The rescale/round/clamp logic SHALL be one combinational sub-module, q_rescale_sat, instantiated four times.

Verification
REQ-031 FRAC_BITS=15; r1=0x00008000, r2=0x3FFF8000, r3=0x40000000, r4=0xBFFF0000, out_ready=1 -> beats 0x0001, 0x7FFF, 0x7FFF (sat=1), 0x8000 (sat=1), out_last on beat 4, first beat at N+1.
REQ-032 Rounding: r1=0xFFFFC000 -> 0x0000; r1=0xFFFFBFFF -> 0xFFFF; r1=0xC0000000 -> 0x8000 with sat=0.
REQ-033 Backpressure: out_ready=0 for 5 cycles mid-burst -> outputs held stable, no beat lost or duplicated.
REQ-034 Overflow: DEPTH=2, out_ready=0, three in_valid pulses -> full=1 after the 2nd, ovf=1 after the 3rd; then out_ready=1 -> exactly 8 beats from the first two results.
REQ-035 Simultaneous events: full FIFO, in_valid on the idx-3 handshake cycle -> accepted, ovf stays 0, full stays 1; then ovf_clr with a concurrent drop -> ovf=1.
REQ-036 Reset: rst low during beat 2 -> out_valid=0 immediately; after release, no output until a new in_valid.
